pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipe_ctrl.
// The master drives the hazard inputs. The slave returns the stage enables and the status.
interface pipe_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  ex_rt;
    logic        ex_memread;
    logic        jump_id;
    logic        branch_taken_ex;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        err;
    logic [1:0]  state;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, ex_rt, ex_memread, jump_id, branch_taken_ex, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, err, state, stall_count
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_memread, jump_id, branch_taken_ex, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, err, state, stall_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: it handles load-use stalls, branch and jump flushes, and data-memory wait states.
// A memory timeout sends the controller to HALT, where it stays until reset.
module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_HALT    = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        P_NORMAL  = 3'd0,
        P_FREEZE  = 3'd1,
        P_LOADUSE = 3'd2,
        P_BRANCH  = 3'd3,
        P_JUMP    = 3'd4
    } profile_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    profile_e    prof;
    profile_e    no_mem_prof;
    logic        load_use;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble;

    assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

    // A taken branch in EX already discards the ID instruction, so it outranks a jump or a load-use stall.
    assign no_mem_prof = bus.branch_taken_ex ? P_BRANCH  :
                         bus.jump_id         ? P_JUMP    :
                         load_use            ? P_LOADUSE : P_NORMAL;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        prof       = P_FREEZE;
        case (state_q)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    prof = no_mem_prof;
                end
            end
            ST_MEMWAIT: begin
                if (!bus.mem_ready) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    prof    = no_mem_prof;
                    state_d = ST_RUN;
                end
            end
            // The HALT state and the unused 2'b11 encoding both hold, with the pipeline frozen.
            default: prof = P_FREEZE;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            case (prof)
                P_NORMAL: begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                end
                P_LOADUSE: begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0011;
                    idex_bubble = 1'b1;
                end
                P_BRANCH: begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                P_JUMP: begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                    ifid_flush  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall_cnt_d = (!pc_en && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.err         = err_q;
    assign bus.state       = state_q;
    assign bus.stall_count = stall_cnt_q;

endmodule
